// File: rtl/rot_state_ctrl.sv
// Rotation-state controller: debounces cw/ccw buttons, accumulates presses and
// applies the net step (plus optional auto-rotate) at the start of vertical blanking.
module rot_state_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_FRAMES     = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_cw,
   input  logic       btn_ccw,
   input  logic       auto_en,
   input  logic       frame_start,
   output logic [1:0] rot_state,
   output logic       rot_changed,
   output logic       pending
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int FRM_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(AUTO_FRAMES - 1);

   // bit 0 = clockwise, bit 1 = counter-clockwise
   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            stable_q, stable_d;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            req;

   logic [1:0]       offset_q, offset_d;
   logic [1:0]       rot_q, rot_d;
   logic             chg_q, chg_d;
   logic [FRM_W-1:0] frm_q, frm_d;
   logic             auto_step;
   logic [1:0]       step;
   logic [1:0]       delta;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      req      = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
               req[i]      = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      auto_step = frame_start && auto_en && (frm_q == FRM_LAST);
      step      = {1'b0, req[0]} + (req[1] ? 2'd3 : 2'd0);
      // a request coinciding with frame_start lands in the freshly cleared offset
      offset_d  = (frame_start ? 2'd0 : offset_q) + step;
      delta     = offset_q + {1'b0, auto_step};
      rot_d     = frame_start ? (rot_q + delta) : rot_q;
      chg_d     = frame_start && (delta != 2'd0);
      frm_d     = frm_q;
      if (!auto_en) begin
         frm_d = '0;
      end else if (frame_start) begin
         frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + FRM_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
         offset_q <= '0;
         rot_q    <= '0;
         chg_q    <= 1'b0;
         frm_q    <= '0;
      end else begin
         sync1_q  <= {btn_ccw, btn_cw};
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         offset_q <= offset_d;
         rot_q    <= rot_d;
         chg_q    <= chg_d;
         frm_q    <= frm_d;
      end
   end

   assign rot_state   = rot_q;
   assign rot_changed = chg_q;
   assign pending     = (offset_q != 2'd0);

endmodule

// File: tb/tb_rot_state_ctrl.sv
// Self-checking bench for rot_state_ctrl: directed scenarios plus random
// button/frame traffic, compared every cycle against a window-based reference model.
module tb_rot_state_ctrl;

   localparam int D = 4;
   localparam int A = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_cw, btn_ccw, auto_en, frame_start;
   logic [1:0] rot_state;
   logic       rot_changed, pending;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int         m_rot, m_off, m_fcnt;
   int         m_chg;
   bit         m_st_cw, m_st_ccw;
   logic [D+1:0] hist_cw, hist_ccw;
   bit         cur_auto;

   always #5 clk = ~clk;

   rot_state_ctrl #(.DEBOUNCE_CYCLES(D), .AUTO_FRAMES(A)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_cw      (btn_cw),
      .btn_ccw     (btn_ccw),
      .auto_en     (auto_en),
      .frame_start (frame_start),
      .rot_state   (rot_state),
      .rot_changed (rot_changed),
      .pending     (pending)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_rot = 0; m_off = 0; m_fcnt = 0; m_chg = 0;
      m_st_cw = 0; m_st_ccw = 0;
      hist_cw = '0; hist_ccw = '0;
   endtask

   // A stable level flips once the synced input (raw delayed two edges) has
   // disagreed with it over the last D edges.
   task automatic model_edge(input bit cw, input bit ccw, input bit au, input bit fs);
      int rc, rcc, ast;
      rc = 0; rcc = 0;
      hist_cw  = {hist_cw[D:0], cw};
      hist_ccw = {hist_ccw[D:0], ccw};
      if (!m_st_cw && (&hist_cw[D+1:2])) begin m_st_cw = 1; rc = 1; end
      else if (m_st_cw && !(|hist_cw[D+1:2])) m_st_cw = 0;
      if (!m_st_ccw && (&hist_ccw[D+1:2])) begin m_st_ccw = 1; rcc = 1; end
      else if (m_st_ccw && !(|hist_ccw[D+1:2])) m_st_ccw = 0;
      ast = (fs && au && m_fcnt == A - 1) ? 1 : 0;
      if (fs) begin
         m_chg = (((m_off + ast) % 4) != 0) ? 1 : 0;
         m_rot = (m_rot + m_off + ast) % 4;
      end else begin
         m_chg = 0;
      end
      m_off = ((fs ? 0 : m_off) + rc + 3 * rcc) % 4;
      if (!au) m_fcnt = 0;
      else if (fs) m_fcnt = (m_fcnt + 1) % A;
   endtask

   // called at a falling edge: drive, clock, then compare at the next falling edge
   task automatic tick(input bit cw, input bit ccw, input bit fs);
      btn_cw = cw; btn_ccw = ccw; auto_en = cur_auto; frame_start = fs;
      @(posedge clk);
      model_edge(cw, ccw, cur_auto, fs);
      @(negedge clk);
      check("rot_state",   int'(rot_state),   m_rot);
      check("rot_changed", int'(rot_changed), m_chg);
      check("pending",     int'(pending),     (m_off != 0) ? 1 : 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press(input bit cw, input bit ccw);
      for (int i = 0; i < D + 3; i++) tick(cw, ccw, 1'b0);
      idle(D + 3);
   endtask

   task automatic frame();
      tick(1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset(input bit cw_held);
      rst = 1'b1; btn_cw = cw_held; btn_ccw = 1'b0; frame_start = 1'b0; auto_en = cur_auto;
      #2;
      check("rst_rot_state",   int'(rot_state),   0);
      check("rst_rot_changed", int'(rot_changed), 0);
      check("rst_pending",     int'(pending),     0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      bit cw, ccw, fs, prev_fs;
      int len;
      rst = 1'b0; btn_cw = 0; btn_ccw = 0; auto_en = 0; frame_start = 0;
      cur_auto = 0;
      model_clear();
      @(negedge clk);

      // 1: long cw hold, frame at cycle 30
      do_reset(1'b0);
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0);
      idle(18);
      frame();
      check("s1_rot", int'(rot_state), 1);
      check("s1_chg", int'(rot_changed), 1);
      idle(1);
      check("s1_chg_drop", int'(rot_changed), 0);
      check("s1_pending", int'(pending), 0);

      // 2: short glitch ignored
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
      idle(10);
      check("s2_pending", int'(pending), 0);
      frame();
      check("s2_rot", int'(rot_state), 0);
      check("s2_chg", int'(rot_changed), 0);

      // 3: three presses then four presses
      do_reset(1'b0);
      for (int p = 0; p < 3; p++) press(1'b1, 1'b0);
      frame();
      check("s3_rot3", int'(rot_state), 3);
      for (int p = 0; p < 4; p++) press(1'b1, 1'b0);
      frame();
      check("s3_rot_wrap", int'(rot_state), 3);
      check("s3_chg_none", int'(rot_changed), 0);

      // 4: ccw wraps backwards, simultaneous presses cancel
      do_reset(1'b0);
      press(1'b0, 1'b1);
      frame();
      check("s4_ccw", int'(rot_state), 3);
      press(1'b1, 1'b1);
      frame();
      check("s4_cancel", int'(rot_state), 3);
      check("s4_cancel_chg", int'(rot_changed), 0);

      // 5: auto rotate every third frame, combined with a press
      do_reset(1'b0);
      cur_auto = 1;
      for (int f = 1; f <= 6; f++) begin
         idle(5);
         frame();
         if (f == 3) check("s5_auto3", int'(rot_state), 1);
         if (f == 6) check("s5_auto6", int'(rot_state), 2);
      end
      idle(3); frame(); idle(3); frame();
      press(1'b1, 1'b0);
      frame();
      check("s5_auto_press", int'(rot_state), 0);
      check("s5_auto_press_chg", int'(rot_changed), 1);
      cur_auto = 0;

      // 6: request coinciding with frame_start is deferred
      do_reset(1'b0);
      for (int i = 0; i < D + 1; i++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      check("s6_defer_rot", int'(rot_state), 0);
      check("s6_defer_pend", int'(pending), 1);
      idle(D + 4);
      frame();
      check("s6_applied", int'(rot_state), 1);

      // 7: reset mid-debounce with offset 2 discards everything
      do_reset(1'b0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      do_reset(1'b0);
      idle(10);
      frame();
      check("s7_rot", int'(rot_state), 0);
      check("s7_chg", int'(rot_changed), 0);

      // 8: random traffic, occasional reset with a button held through it
      do_reset(1'b1);
      prev_fs = 0;
      for (int seg = 0; seg < 400; seg++) begin
         len = $urandom_range(1, 9);
         cw  = ($urandom_range(0, 2) == 0);
         ccw = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) cur_auto = ~cur_auto;
         if ($urandom_range(0, 60) == 0) do_reset(cw);
         for (int i = 0; i < len; i++) begin
            fs = !prev_fs && ($urandom_range(0, 7) == 0);
            tick(cw, ccw, fs);
            prev_fs = fs;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rot_state_ctrl.md
# rot_state_ctrl

Generates the 2-bit `rot_state` consumed by the on-screen symbol renderers, so the displayed shape and colour change in response to user input. Debounces two raw push-buttons, one for clockwise and one for counter-clockwise, and accumulates the presses. The accumulated step is applied only at the start of vertical blanking, so a symbol never changes shape mid-frame. An optional auto-rotate mode advances the state every N frames.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000, consecutive stable clocks required to accept a button level change (10 ms at 50 MHz).
- `AUTO_FRAMES`, 60, frames between automatic +1 steps when `auto_en` is high; legal values are ≥1.

Ports:
- `clk`  input  1  system/pixel-domain clock.
- `rst`  input  1  asynchronous, active-high reset.
- `btn_cw`  input  1  raw clockwise button, asynchronous, active-high.
- `btn_ccw`  input  1  raw counter-clockwise button, asynchronous, active-high.
- `auto_en`  input  1  auto-rotate enable, synchronous to `clk`.
- `frame_start`  input  1  one-cycle pulse at the start of vertical blanking, from the VGA timing generator.
- `rot_state`  output  2  current rotation state, fed to symbol renderers.
- `rot_changed`  output  1  one-cycle pulse, high in the first cycle a new `rot_state` value is visible.
- `pending`  output  1  high while the accumulated offset is non-zero.

## Operation
- **Synchronizers:** each button passes through a 2-flop synchronizer.
- **Debounce, per button:**
  - A stable level register and a counter are kept for each button.
  - When the synced input ≠ stable, the counter increments. When it equals stable, the counter clears.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still mismatched, stable takes the input value and the counter clears.
- **Requests:**
  - A 0→1 transition of a stable level produces a one-cycle request: `req_cw` or `req_ccw`.
  - Releases produce nothing.
- **Offset accumulator:** a 2-bit mod-4 register `offset`.
  - `step = (req_cw ? 1 : 0) + (req_ccw ? 3 : 0)`, mod 4. Simultaneous cw and ccw requests cancel.
  - `offset_next = (frame_start ? 0 : offset) + step`. A request arriving in the same cycle as `frame_start` is deferred to the next frame.
- **Frame counter:**
  - Range is 0..`AUTO_FRAMES-1`. It increments on each `frame_start` while `auto_en` is high, and wraps to 0.
  - It is held at 0 while `auto_en` is low.
  - `auto_step` = 1 when `frame_start` is high, `auto_en` is high, and the counter = `AUTO_FRAMES-1`; otherwise 0.
- **Apply:** on a `frame_start` cycle, `rot_state <= rot_state + offset + auto_step` (mod 4).
- **`rot_changed`:** registered as `frame_start && ((offset + auto_step) mod 4 != 0)`. It is therefore high in the cycle after the `frame_start` edge, together with the new `rot_state`.
- **`pending`:** `offset != 0`. It is combinational from the register.
- **Wrap-around:** 3+1 → 0 and 0−1 → 3. Four net presses within one frame leave `rot_state` unchanged and no `rot_changed` pulse is produced.

## Timing
- **Reset values:** `rot_state=0`, `rot_changed=0`, `pending=0`. All synchronizer flops, stable levels, debounce counters, `offset` and the frame counter are 0.
- **Reset mid-operation:** partial debounce counts and the pending offset are discarded.
- **Button held through reset release:** it is treated as a new press. It is accepted `2+DEBOUNCE_CYCLES` cycles after release, because the stable level starts at 0.
- **Press latency:** the request pulse occurs 2 (sync) + `DEBOUNCE_CYCLES` cycles after the raw edge, ±1 cycle.
- **Apply latency:** `rot_state` and `rot_changed` update 1 cycle after the `frame_start` pulse and remain stable for the whole following frame.
- **Glitches:** pulses or bounces shorter than `DEBOUNCE_CYCLES` are ignored.
- **`frame_start` width:** assumed exactly one cycle. A multi-cycle pulse applies the offset on the first cycle only, because the offset is cleared. Auto-rotate counts every high cycle, so the generator must guarantee a single-cycle pulse.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `AUTO_FRAMES=3`.
- Hold `btn_cw` 12 cycles, then `frame_start` at cycle 30 → `pending` rises about cycle 7; `rot_state` goes 0→1 at cycle 31; `rot_changed` is high in cycle 31 only; `pending` then falls.
- 3-cycle `btn_cw` glitch, then `frame_start` → `rot_state` stays 0, no `rot_changed`, `pending` stays 0.
- Three clean `btn_cw` presses, then `frame_start` → `rot_state` 0→3. Repeat with four presses → `rot_state` unchanged, no pulse.
- From `rot_state=0`, one `btn_ccw` press, then `frame_start` → 3. Simultaneous cw and ccw presses → no change.
- `auto_en=1`, six `frame_start` pulses and no buttons → `rot_state` increments on the 3rd and 6th pulses (0→1→2). A cw press before the 3rd pulse → 0→2 on that pulse.
- Debounced request in the same cycle as `frame_start` → not applied; it is applied at the next `frame_start`. Assert `rst` mid-debounce with `offset=2` → all outputs return to 0, and nothing is applied at the subsequent `frame_start`.
